// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ENC_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ENC_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ENC_DONE = 2'd2;

  typedef enum logic [ST_W-1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    DONE = ENC_DONE
  } state_t;

  // Bit counter width able to hold 0..w
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Carries the overflow flag when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
`ifdef SERIAL_ADD_OVF_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
`ifdef SERIAL_ADD_OVF_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder shared across all bit positions.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB first, one bit per cycle.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             c_reg;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             s_c;
  logic             cout_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  serial_fa_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c_reg),
    .s    (s_c),
    .cout (cout_c)
  );

  // Sequencer: load on accept, shift one bit per RUN cycle, hold result in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      c_reg       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            c_reg      <= bus.carry_in;
            sum_sh     <= '0;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= WIDTH'({s_c, sum_sh} >> 1);
          c_reg  <= cout_c;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            // Carry into the MSB differs from carry out of it
            ovf_q       <= c_reg ^ cout_c;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_sh;
  assign bus.carry_out = c_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule
